// File: rtl/nonogram_pkg.sv
// Shared definitions for the nonogram puzzle pipeline: board limits,
// loader FSM states and sticky error-bit positions.
package nonogram_pkg;

  localparam int MAX_ROWS        = 11;
  localparam int MAX_COLS        = 11;
  localparam int MAX_NUM_OPTIONS = 84;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } loader_state_t;

  localparam int ERR_ORDER     = 3;
  localparam int ERR_INDEX     = 2;
  localparam int ERR_LINE_FULL = 1;
  localparam int ERR_MEM_FULL  = 0;

endpackage

// File: rtl/option_loader_line_table.sv
// Per-line {base, count} register file: one init/increment write port,
// a combinational count tap for the current line and a registered lookup port.
module line_table #(
  parameter int NUM_LINES = 22,
  parameter int AW        = 10,
  parameter int LW        = 5,
  parameter int CW        = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          init,
  input  logic [LW-1:0] init_idx,
  input  logic [AW-1:0] init_base,
  input  logic          inc,
  input  logic [LW-1:0] cur_idx,
  output logic [CW-1:0] cur_count,
  input  logic          q_valid,
  input  logic [LW-1:0] q_line,
  output logic          r_valid,
  output logic [AW-1:0] r_base,
  output logic [CW-1:0] r_count
);

  localparam logic [LW:0] NUM_LINES_W = (LW+1)'(NUM_LINES);

  logic [AW-1:0] base_reg  [NUM_LINES];
  logic [CW-1:0] count_reg [NUM_LINES];

  logic          r_valid_reg;
  logic [AW-1:0] r_base_reg;
  logic [CW-1:0] r_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        base_reg[i]  <= '0;
        count_reg[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        base_reg[i]  <= '0;
        count_reg[i] <= '0;
      end
    end else if (init) begin
      base_reg[init_idx]  <= init_base;
      count_reg[init_idx] <= '0;
    end else if (inc) begin
      count_reg[cur_idx] <= count_reg[cur_idx] + CW'(1);
    end
  end

  assign cur_count = count_reg[cur_idx];

  // Reads sample the table before this edge's update, so a same-cycle
  // lookup of a line being modified sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_reg <= 1'b0;
      r_base_reg  <= '0;
      r_count_reg <= '0;
    end else begin
      r_valid_reg <= q_valid;
      if (q_valid) begin
        if ({1'b0, q_line} < NUM_LINES_W) begin
          r_base_reg  <= base_reg[q_line];
          r_count_reg <= count_reg[q_line];
        end else begin
          r_base_reg  <= '0;
          r_count_reg <= '0;
        end
      end
    end
  end

  assign r_valid = r_valid_reg;
  assign r_base  = r_base_reg;
  assign r_count = r_count_reg;

endmodule

// File: rtl/option_loader.sv
// Loads the parser's header/option word stream into the option BRAM and
// records per-line base address and option count for the solver.
module option_loader #(
  parameter int MAX_ROWS        = nonogram_pkg::MAX_ROWS,
  parameter int MAX_COLS        = nonogram_pkg::MAX_COLS,
  parameter int MAX_NUM_OPTIONS = nonogram_pkg::MAX_NUM_OPTIONS,
  parameter int MEM_DEPTH       = 1024,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int LW = $clog2(MAX_ROWS + MAX_COLS),
  localparam int CW = $clog2(MAX_NUM_OPTIONS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic          in_header,
  input  logic [15:0]   in_word,
  input  logic          board_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [15:0]   mem_wdata,
  input  logic          q_valid,
  input  logic [LW-1:0] q_line,
  output logic          r_valid,
  output logic [AW-1:0] r_base,
  output logic [CW-1:0] r_count,
  output logic          loaded,
  output logic [LW:0]   lines_seen,
  output logic [3:0]    err
);

  import nonogram_pkg::*;

  localparam int          NUM_LINES   = MAX_ROWS + MAX_COLS;
  localparam logic [LW:0] NUM_LINES_W = (LW+1)'(NUM_LINES);
  localparam logic [AW:0] DEPTH_W     = (AW+1)'(MEM_DEPTH);
  localparam logic [CW-1:0] MAX_CNT_W = CW'(MAX_NUM_OPTIONS);

  loader_state_t state_reg, state_next;
  logic [AW:0]   wptr_reg, wptr_next;
  logic [LW-1:0] cur_reg, cur_next;
  logic [LW:0]   lines_reg, lines_next;
  logic [3:0]    err_reg, err_next;
  logic          loaded_reg, loaded_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] waddr_reg, waddr_next;
  logic [15:0]   wdata_reg, wdata_next;

  logic          tbl_init;
  logic          tbl_inc;
  logic [CW-1:0] cur_count;
  logic [LW-1:0] hdr_idx;
  logic          hdr_ok;

  assign hdr_idx = in_word[LW-1:0];
  assign hdr_ok  = ({1'b0, hdr_idx} < NUM_LINES_W);

  line_table #(
    .NUM_LINES (NUM_LINES),
    .AW        (AW),
    .LW        (LW),
    .CW        (CW)
  ) u_line_table (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .init      (tbl_init),
    .init_idx  (hdr_idx),
    .init_base (wptr_reg[AW-1:0]),
    .inc       (tbl_inc),
    .cur_idx   (cur_reg),
    .cur_count (cur_count),
    .q_valid   (q_valid),
    .q_line    (q_line),
    .r_valid   (r_valid),
    .r_base    (r_base),
    .r_count   (r_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      wptr_reg   <= '0;
      cur_reg    <= '0;
      lines_reg  <= '0;
      err_reg    <= '0;
      loaded_reg <= 1'b0;
      mem_we_reg <= 1'b0;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      wptr_reg   <= wptr_next;
      cur_reg    <= cur_next;
      lines_reg  <= lines_next;
      err_reg    <= err_next;
      loaded_reg <= loaded_next;
      mem_we_reg <= mem_we_next;
      waddr_reg  <= waddr_next;
      wdata_reg  <= wdata_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wptr_next   = wptr_reg;
    cur_next    = cur_reg;
    lines_next  = lines_reg;
    err_next    = err_reg;
    loaded_next = loaded_reg;
    mem_we_next = 1'b0;
    waddr_next  = waddr_reg;
    wdata_next  = wdata_reg;
    tbl_init    = 1'b0;
    tbl_inc     = 1'b0;

    if (clear) begin
      state_next  = ST_IDLE;
      wptr_next   = '0;
      cur_next    = '0;
      lines_next  = '0;
      err_next    = '0;
      loaded_next = 1'b0;
    end else begin
      if (in_valid) begin
        case (state_reg)
          ST_IDLE, ST_LINE: begin
            if (in_header) begin
              if (hdr_ok) begin
                tbl_init   = 1'b1;
                cur_next   = hdr_idx;
                lines_next = lines_reg + (LW+1)'(1);
                state_next = ST_LINE;
              end else begin
                err_next[ERR_INDEX] = 1'b1;
                state_next          = ST_ERR;
              end
            end else if (state_reg == ST_IDLE) begin
              err_next[ERR_ORDER] = 1'b1;
              state_next          = ST_ERR;
            end else if (cur_count == MAX_CNT_W) begin
              err_next[ERR_LINE_FULL] = 1'b1;
            end else if (wptr_reg == DEPTH_W) begin
              err_next[ERR_MEM_FULL] = 1'b1;
              state_next             = ST_ERR;
            end else begin
              mem_we_next = 1'b1;
              waddr_next  = wptr_reg[AW-1:0];
              wdata_next  = in_word;
              wptr_next   = wptr_reg + (AW+1)'(1);
              tbl_inc     = 1'b1;
            end
          end
          ST_DONE: err_next[ERR_ORDER] = 1'b1;
          default: ;
        endcase
      end
      // board_done acts on the state left behind by this cycle's word.
      if (board_done && (state_next == ST_IDLE || state_next == ST_LINE)) begin
        state_next  = ST_DONE;
        loaded_next = 1'b1;
      end
    end
  end

  assign mem_we     = mem_we_reg;
  assign mem_waddr  = waddr_reg;
  assign mem_wdata  = wdata_reg;
  assign loaded     = loaded_reg;
  assign lines_seen = lines_reg;
  assign err        = err_reg;

endmodule

// File: doc/option_loader.md
# option_loader

Stage directly downstream of the puzzle parser. Consumes the parser's 16-bit word stream (line headers and option bitmasks) and writes every option into the option BRAM through a single write port. Records per line the BRAM base address and the option count, and serves them to the solver through a registered lookup port. Flags malformed streams and capacity overflows with sticky error bits.

## Interface
Parameters:
- MAX_ROWS, 11, maximum board rows
- MAX_COLS, 11, maximum board columns
- MAX_NUM_OPTIONS, 84, maximum options per line
- MEM_DEPTH, 1024, option BRAM depth in words; AW = $clog2(MEM_DEPTH), LW = $clog2(MAX_ROWS+MAX_COLS), CW = $clog2(MAX_NUM_OPTIONS+1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- clear  in  1  synchronous restart for a new board
- in_valid  in  1  word present this cycle; always accepted, no backpressure
- in_header  in  1  word is a line header; in_word[LW-1:0] = line index
- in_word  in  16  header or option bitmask
- board_done  in  1  one-cycle pulse: board finished
- mem_we  out  1  BRAM write enable
- mem_waddr  out  AW  BRAM write address
- mem_wdata  out  16  BRAM write data
- q_valid  in  1  lookup request
- q_line  in  LW  line to look up
- r_valid  out  1  lookup response valid
- r_base  out  AW  base address of line
- r_count  out  CW  option count of line
- loaded  out  1  table complete, lookups meaningful
- lines_seen  out  LW+1  number of headers accepted
- err  out  4  sticky {order, index, line_full, mem_full}

## Operation
- States: IDLE (no header yet), LINE (collecting options), DONE, ERR.
- IDLE/LINE + header: index < MAX_ROWS+MAX_COLS -> base[idx] <= wptr, count[idx] <= 0, cur <= idx, lines_seen++, -> LINE. Index out of range -> err[2], -> ERR.
- LINE + option word: count[cur] == MAX_NUM_OPTIONS -> err[1], word dropped, stay LINE. wptr == MEM_DEPTH -> err[0], dropped, -> ERR. Otherwise write in_word at wptr, wptr++, count[cur]++.
- IDLE + option word: err[3], -> ERR.
- board_done in IDLE/LINE -> DONE, loaded <= 1. In ERR: stays ERR, loaded stays 0.
- DONE + any in_valid: err[3], word dropped, state stays DONE.
- ERR: absorbs all input; no writes; exits only on clear or rst.
- clear (any state): wptr, lines_seen, err, loaded, cur <= 0; base/count tables zeroed; -> IDLE.
- Duplicate header index: re-base the line to the current wptr (earlier words orphaned), no error.
- wptr is AW+1 bits wide so MEM_DEPTH is representable; no wrap-around.

## Timing
- Reset values: all outputs 0, state IDLE, tables zero.
- Write latency: option accepted at edge N -> mem_we=1 with addr/data registered during cycle N+1. mem_we is high for exactly one cycle per accepted option.
- Headers produce no BRAM write.
- Lookup: q_valid at edge N -> r_valid, r_base, r_count valid in cycle N+1 (one cycle), in any state. A lookup in the same cycle as an update to that line returns the pre-update value.
- Same-cycle in_valid and board_done: the word is processed first and the DONE transition applies to the resulting state. Example: a legal option is written and the block enters DONE.
- Same-cycle clear and in_valid/board_done: clear wins; the word is dropped.
- rst mid-board: immediate asynchronous return to reset values. A pending mem_we is cancelled.

## Structure
- Shared package nonogram_pkg: localparams MAX_ROWS, MAX_COLS, MAX_NUM_OPTIONS; state enum loader_state_t; error-bit index constants ERR_ORDER/ERR_INDEX/ERR_LINE_FULL/ERR_MEM_FULL.
- One sub-module, line_table: register file of MAX_ROWS+MAX_COLS entries {base, count}, with a write/increment port and a registered read port. The top level holds the FSM, wptr and the write pipeline.

## Test plan
- Header 0; options 0x0005, 0x0006; header 1; option 0x0003; board_done -> writes at addr 0, 1, 2 with those data; lookup line 1 -> base 2, count 1; loaded=1; lines_seen=2.
- Option word before any header -> err=4'b1000, no mem_we; clear -> err=0, state IDLE.
- Header index 22 (MAX_ROWS+MAX_COLS) -> err[2] set; subsequent options produce no writes.
- 85 options on one line -> 84 writes, err[1] set, count reads 84.
- MEM_DEPTH=4; 5 options -> 4 writes, err[0], state ERR; board_done leaves loaded=0.
- in_valid with clear in the same cycle -> no write. in_valid with board_done in the same cycle -> the write occurs and loaded=1 the following cycle. rst asserted mid-stream -> all outputs 0 immediately.
